// File: rtl/seven_segment_reader.sv
// ============================================================================
//  Module      : seven_segment_reader
//  Description : Recovers the signed 4-bit value shown on a two-digit,
//                active-low seven-segment display (sign digit + magnitude
//                digit). Glitches are filtered by a stability counter, and
//                each newly settled pattern is reported once over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] sign_n,
    input  logic [6:0] seg_n,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_value,
    output logic       out_err,
    output logic       overrun
);

    localparam int                 c_CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX    = c_CNT_W'(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [13:0]        c_IDLE       = 14'h3FFF;
    localparam logic [6:0]         c_SIGN_BLANK = 7'b1111111;
    localparam logic [6:0]         c_SIGN_MINUS = 7'b1111110;

    logic [13:0]        r_s_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_armed;
    logic               r_out_valid;
    logic [3:0]         r_out_value;
    logic               r_out_err;
    logic               r_overrun;

    logic [13:0] w_p;
    logic        w_same;
    logic        w_accept;
    logic        w_report;
    logic [6:0]  w_sign;
    logic [6:0]  w_digit;
    logic [3:0]  w_mag;
    logic        w_mag_ok;
    logic [3:0]  w_dec_value;
    logic        w_dec_err;

    assign w_p      = {sign_n, seg_n};
    assign w_same   = (w_p == r_s_q);
    assign w_accept = w_same && (r_cnt == c_CNT_LAST) && r_armed;
    // A settled blank display is consumed without producing a report.
    assign w_report = w_accept && (r_s_q != c_IDLE);

    // At accept time the sample register equals the live inputs, so decode
    // from the register to keep the input-to-output path short.
    assign w_sign  = r_s_q[13:7];
    assign w_digit = r_s_q[6:0];

    always_comb begin
        w_mag    = 4'd0;
        w_mag_ok = 1'b1;
        case (w_digit)
            7'b0000001: w_mag = 4'd0;
            7'b1001111: w_mag = 4'd1;
            7'b0010010: w_mag = 4'd2;
            7'b0000110: w_mag = 4'd3;
            7'b1001100: w_mag = 4'd4;
            7'b0100100: w_mag = 4'd5;
            7'b0100000: w_mag = 4'd6;
            7'b0001111: w_mag = 4'd7;
            7'b0000000: w_mag = 4'd8;
            default:    w_mag_ok = 1'b0;
        endcase
    end

    // Positive range is 0..7 and negative range is -1..-8, so "+8" and "-0"
    // fall out as errors along with any unknown sign or digit code.
    always_comb begin
        w_dec_value = 4'd0;
        w_dec_err   = 1'b1;
        if (w_mag_ok) begin
            if ((w_sign == c_SIGN_BLANK) && (w_mag <= 4'd7)) begin
                w_dec_value = w_mag;
                w_dec_err   = 1'b0;
            end else if ((w_sign == c_SIGN_MINUS) && (w_mag != 4'd0)) begin
                w_dec_value = 4'd0 - w_mag;
                w_dec_err   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_q       <= c_IDLE;
            r_cnt       <= '0;
            r_armed     <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_value <= 4'd0;
            r_out_err   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_s_q <= w_p;

            if (!w_same) begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            if (w_accept) begin
                r_armed <= 1'b0;
            end

            // A report loads if the holding slot is free or is being drained
            // on this same edge; otherwise it is dropped and flagged.
            if (w_report && (!r_out_valid || out_ready)) begin
                r_out_valid <= 1'b1;
                r_out_value <= w_dec_value;
                r_out_err   <= w_dec_err;
            end else begin
                if (w_report) begin
                    r_overrun <= 1'b1;
                end
                if (r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_value = r_out_value;
    assign out_err   = r_out_err;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_reader.sv
// ============================================================================
//  Module      : tb_seven_segment_reader
//  Description : Self-checking bench for seven_segment_reader: vector table,
//                hand sequences for timing corners, randomized traffic
//                against a display-encoder based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seven_segment_reader;

    localparam int         STABLE  = 4;
    localparam logic [6:0] c_BLANK = 7'b1111111;
    localparam logic [6:0] c_MINUS = 7'b1111110;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] sign_n = 7'h7F;
    logic [6:0] seg_n = 7'h7F;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [3:0] out_value;
    logic       out_err;
    logic       overrun;

    seven_segment_reader #(.STABLE_CYCLES(STABLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .sign_n   (sign_n),
        .seg_n    (seg_n),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_value(out_value),
        .out_err  (out_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Display encoder: the forward path, from a value to its segment pattern.
    function automatic logic [6:0] dcode(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] enc(input int v);
        if (v < 0) return {c_MINUS, dcode(-v)};
        return {c_BLANK, dcode(v)};
    endfunction

    // Readback is the inverse of the encoder over the 16 displayable values.
    task automatic ref_decode(input logic [13:0] p, output logic [3:0] val, output logic err);
        val = 4'd0;
        err = 1'b1;
        for (int v = -8; v <= 7; v++) begin
            if (enc(v) == p) begin
                val = 4'(v);
                err = 1'b0;
            end
        end
    endtask

    // Reference model: run length of the current pattern; report when it has
    // been seen on STABLE+1 consecutive edges.
    logic [13:0] m_prev  = 14'h3FFF;
    int          m_run   = 1;
    logic        m_valid = 1'b0;
    logic [3:0]  m_value = 4'd0;
    logic        m_err   = 1'b0;
    logic        m_ovr   = 1'b0;
    logic [13:0] m_p;
    bit          m_acc;

    always @(posedge clk) begin
        if (rst) begin
            m_prev = 14'h3FFF; m_run = 1;
            m_valid = 1'b0; m_value = 4'd0; m_err = 1'b0; m_ovr = 1'b0;
        end else begin
            m_p   = {sign_n, seg_n};
            m_acc = 1'b0;
            if (m_p == m_prev) begin
                m_run++;
                if (m_run == STABLE + 1) m_acc = 1'b1;
            end else begin
                m_prev = m_p;
                m_run  = 1;
            end
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_acc && m_p != 14'h3FFF) begin
                if (!m_valid) begin
                    ref_decode(m_p, m_value, m_err);
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", 32'(out_valid), 32'(m_valid));
            chk("model_overrun", 32'(overrun), 32'(m_ovr));
            if (m_valid) begin
                chk("model_value", 32'(out_value), 32'(m_value));
                chk("model_err", 32'(out_err), 32'(m_err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a pattern and wait (bounded) for the first report it causes.
    task automatic present(input logic [6:0] s, input logic [6:0] d, input int budget,
                           output int first, output logic [3:0] val, output logic err);
        sign_n = s;
        seg_n  = d;
        first  = -1;
        val    = 4'd0;
        err    = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (out_valid && first < 0) begin
                first = i;
                val   = out_value;
                err   = out_err;
                break;
            end
        end
    endtask

    typedef struct {
        logic [6:0] sign;
        logic [6:0] seg;
        logic [3:0] value;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int         first, nv, pulses;
    logic [3:0] val;
    logic       err;

    initial begin
        vecs.push_back('{c_MINUS, 7'b0000000, 4'b1000, 1'b0});
        vecs.push_back('{c_MINUS, 7'b1001111, 4'b1111, 1'b0});
        vecs.push_back('{c_MINUS, 7'b0010010, 4'b1110, 1'b0});
        vecs.push_back('{c_MINUS, 7'b0000110, 4'b1101, 1'b0});
        vecs.push_back('{c_MINUS, 7'b1001100, 4'b1100, 1'b0});
        vecs.push_back('{c_MINUS, 7'b0100100, 4'b1011, 1'b0});
        vecs.push_back('{c_MINUS, 7'b0100000, 4'b1010, 1'b0});
        vecs.push_back('{c_MINUS, 7'b0001111, 4'b1001, 1'b0});
        vecs.push_back('{c_BLANK, 7'b0000001, 4'd0, 1'b0});
        vecs.push_back('{c_BLANK, 7'b1001111, 4'd1, 1'b0});
        vecs.push_back('{c_BLANK, 7'b0010010, 4'd2, 1'b0});
        vecs.push_back('{c_BLANK, 7'b0000110, 4'd3, 1'b0});
        vecs.push_back('{c_BLANK, 7'b1001100, 4'd4, 1'b0});
        vecs.push_back('{c_BLANK, 7'b0100100, 4'd5, 1'b0});
        vecs.push_back('{c_BLANK, 7'b0100000, 4'd6, 1'b0});
        vecs.push_back('{c_BLANK, 7'b0001111, 4'd7, 1'b0});
        vecs.push_back('{c_MINUS, 7'b0000001, 4'd0, 1'b1});
        vecs.push_back('{c_BLANK, 7'b0000000, 4'd0, 1'b1});
        vecs.push_back('{c_MINUS, 7'b1111111, 4'd0, 1'b1});
        vecs.push_back('{7'b0000000, 7'b0000001, 4'd0, 1'b1});
        vecs.push_back('{c_BLANK, 7'b1111110, 4'd0, 1'b1});

        // Reset, then a quiet idle display.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_value", 32'(out_value), 0);
        chk("rst_err", 32'(out_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk_en = 1'b1;
        nv = 0;
        repeat (20) begin
            tick();
            if (out_valid || overrun) nv++;
        end
        chk("idle_quiet", 32'(nv), 0);

        // Latency and single-pulse behaviour for a held "3".
        present(c_BLANK, 7'b0000110, 20, first, val, err);
        chk("latency_edges", 32'(first - 1), 32'(STABLE));
        chk("latency_value", 32'(val), 32'd3);
        chk("latency_err", 32'(err), 0);
        pulses = 0;
        repeat (15) begin
            tick();
            if (out_valid) pulses++;
        end
        chk("no_repeat", 32'(pulses), 0);

        // Vector table: every legal value plus illegal codes.
        foreach (vecs[i]) begin
            present(vecs[i].sign, vecs[i].seg, STABLE + 8, first, val, err);
            chk("vec_seen", 32'(first > 0), 1);
            chk("vec_value", 32'(val), 32'(vecs[i].value));
            chk("vec_err", 32'(err), 32'(vecs[i].err));
            chk("vec_encoder", 32'(enc(vecs[i].err ? 0 : $signed(vecs[i].value)) ==
                                   {vecs[i].sign, vecs[i].seg}), 32'(!vecs[i].err));
        end

        // Glitching between 2 and 3 must never settle.
        nv = 0;
        repeat (6) begin
            sign_n = c_BLANK; seg_n = 7'b0010010;
            repeat (2) begin tick(); if (out_valid) nv++; end
            seg_n = 7'b0000110;
            repeat (2) begin tick(); if (out_valid) nv++; end
        end
        chk("glitch_quiet", 32'(nv), 0);
        pulses = 0;
        val = 4'd0;
        repeat (12) begin
            tick();
            if (out_valid) begin pulses++; val = out_value; end
        end
        chk("glitch_settle_count", 32'(pulses), 1);
        chk("glitch_settle_value", 32'(val), 32'd3);

        // Overrun: consumer stalled while a second report arrives.
        out_ready = 1'b0;
        sign_n = c_BLANK; seg_n = 7'b0100100;
        repeat (6) tick();
        seg_n = 7'b0100000;
        repeat (6) tick();
        chk("ovr_valid", 32'(out_valid), 1);
        chk("ovr_value_held", 32'(out_value), 32'd5);
        chk("ovr_flag", 32'(overrun), 1);
        out_ready = 1'b1;
        tick();
        chk("ovr_drain", 32'(out_valid), 0);
        chk("ovr_sticky", 32'(overrun), 1);

        // Reset in the middle of a stability count.
        seg_n = 7'b0010010;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_overrun", 32'(overrun), 0);
        present(c_BLANK, 7'b0010010, 20, first, val, err);
        chk("midrst_first", 32'(first), 32'(STABLE + 1));
        chk("midrst_value", 32'(val), 32'd2);

        // Randomized traffic against the model.
        for (int s = 0; s < 250; s++) begin
            int kind, hold;
            kind = $urandom_range(99);
            hold = $urandom_range(8, 1);
            if (kind < 60) {sign_n, seg_n} = enc($urandom_range(15) - 8);
            else if (kind < 75) {sign_n, seg_n} = 14'h3FFF;
            else {sign_n, seg_n} = 14'($urandom);
            repeat (hold) begin
                out_ready = ($urandom_range(3) != 0);
                tick();
            end
        end
        out_ready = 1'b1;
        repeat (3) tick();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
